multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath: PC, instruction register, register file, ALU, sign-extension unit, data memory and the operand/write-back muxes. It replaces the per-opcode combinational control decode with a Moore FSM. Each instruction is split into fetch, decode, execute, memory and write-back steps, and the block emits all mux selects, write enables and memory strobes for each step. It also stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, synchronous, active-high.
- opcode  in  6  instruction[31:26] from the instruction register; sampled in DECODE.
- Zero  in  1  ALU zero flag; used in BRANCH.
- MemReady  in  1  memory access complete; qualifies FETCH, MEMREAD and MEMWRITE.
- PCWrite  out  1  PC load enable (branch condition already folded in).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  write-back data select: 0 = ALUOut, 1 = memory data.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- ALUOp  out  2  to ALUControl: 00 = add, 01 = sub, 10 = use funct.
- PCSource  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- State  out  4  current state encoding, for debug.
- IllegalOp  out  1  sticky illegal-opcode flag.
- Retired  out  CNT_W  retired-instruction count.

## Operation
State encodings and the active outputs in each state (every output not listed is 0):
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0. IRWrite=1 and PCWrite=1 only in a cycle where MemReady=1. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=3, ALUOp=00 (precomputes the branch target). Dispatch on opcode:
  - 0 (R-type) → EXECUTE
  - 35 (lw) or 43 (sw) → MEMADR
  - 4 (beq) → BRANCH
  - 2 (j) → JUMP
  - 8 (addi) → ADDIEX
  - any other opcode → FETCH, with IllegalOp set.
- MEMADR (2): ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD (3): MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB (4): RegWrite=1, RegDst=0, MemtoReg=1. Next state FETCH; retires.
- MEMWRITE (5): MemWrite=1, IorD=1. Waits for MemReady, then goes to FETCH; retires.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=0, ALUOp=10. Next state ALUWB.
- ALUWB (7): RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH; retires.
- BRANCH (8): ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCSource=1, PCWrite=Zero. Next state FETCH; retires.
- JUMP (9): PCSource=2, PCWrite=1. Next state FETCH; retires.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next state ADDIWB.
- ADDIWB (11): RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH; retires.

Unused encodings 12–15 go to FETCH on the next clock, with all outputs 0.

Counter and flag rules:
- Retired increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- Illegal opcodes do not retire.
- IllegalOp is sticky until RESET.

## Timing
- RESET sampled high at a posedge sets: State=FETCH, Retired=0, IllegalOp=0.
- While RESET is held, FETCH outputs are driven but IRWrite and PCWrite are forced to 0.
- RESET in the middle of an instruction aborts it. No RegWrite, MemWrite or PCWrite is issued after that edge.
- Outputs are combinational from the state register, plus MemReady for IRWrite/PCWrite in FETCH and Zero for PCWrite in BRANCH. Outputs change only after the posedge, except that PCWrite/IRWrite follow MemReady within the cycle.
- Latency with MemReady always 1:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - addi: 4 cycles
  - illegal opcode: 2 cycles
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle. Strobes are held stable during the stall.
- MemReady is ignored in every other state.
- opcode is sampled only in DECODE (IR is stable from then on). Zero is sampled only in BRANCH.

## Test plan
- Reset, then R-type (opcode 0) with MemReady=1: State sequence 0,1,6,7,0. RegWrite=1 only in state 7, with RegDst=1. Retired=1 after 4 cycles.
- lw (35) with MemReady low for 2 cycles in MEMREAD: sequence 0,1,2,3,3,3,4,0. MemRead and IorD=1 held for all three cycles in state 3. Total 7 cycles.
- beq (4), run twice, with Zero=1 then Zero=0: PCWrite=1 in state 8 for the first run only, with PCSource=1 both times. Retired increments by 2.
- Opcode 6'h3F: sequence 0,1,0. IllegalOp=1 and stays 1. Retired unchanged. Next sw (43) completes normally in 4 cycles.
- RESET asserted in MEMWRITE during a MemReady=0 stall: MemWrite=0 and State=0 after that edge. Retired=0 and IllegalOp=0.
- With CNT_W=4, retire 17 j (2) instructions: Retired=1 (wrap-around). PCWrite=1, PCSource=2 in each state-9 cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore-style sequencer for a multi-cycle MIPS datapath. Each instruction is
// walked through fetch / decode / execute / memory / write-back steps, and
// every step drives the datapath mux selects, write enables and memory
// strobes. Memory steps stall on MemReady, unknown opcodes set a sticky flag,
// and completed instructions are counted.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   opcode[5:0]         instruction[31:26], sampled in DECODE
//   Zero                ALU zero flag, used in BRANCH
//   MemReady            memory handshake for FETCH / MEMREAD / MEMWRITE
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]   datapath controls
//   State[3:0]          current state, for debug
//   IllegalOp           sticky illegal-opcode flag
//   Retired[CNT_W-1:0]  retired-instruction count (wraps)
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [5:0]       opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t state;
  // Remembers lw vs sw so opcode only has to be looked at in DECODE.
  logic   is_sw;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_FETCH;
      Retired   <= '0;
      IllegalOp <= 1'b0;
      is_sw     <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          is_sw <= (opcode == OP_SW);
          case (opcode)
            OP_RTYPE:     state <= S_EXECUTE;
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDIEX;
            default: begin
              // Unknown opcode is dropped without retiring.
              state     <= S_FETCH;
              IllegalOp <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state <= is_sw ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWRITE: if (MemReady) begin
          state   <= S_FETCH;
          Retired <= Retired + CNT_W'(1);
        end
        S_EXECUTE:  state <= S_ALUWB;
        S_ADDIEX:   state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state   <= S_FETCH;
          Retired <= Retired + CNT_W'(1);
        end
        default:    state <= S_FETCH;
      endcase
    end
  end

  assign State = state;

  // Output decode from the state register. Only IRWrite/PCWrite look at
  // inputs (MemReady in FETCH, Zero in BRANCH); RESET blocks the fetch-side
  // writes so nothing loads while reset is held.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUOp    = 2'b00;
    PCSource = 2'd0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady & ~RESET;
        PCWrite = MemReady & ~RESET;
      end
      S_DECODE:   ALUSrcB = 2'd3;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'd1;
        PCWrite  = Zero;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_ADDIWB:   RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a default-width instance and a CNT_W=4
// instance share all inputs. A queue-of-steps model predicts the state walk
// of each instruction, and a per-state output table predicts the controls.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;

  logic        PCWrite_a, IorD_a, MemRead_a, MemWrite_a, IRWrite_a, RegDst_a;
  logic        MemtoReg_a, RegWrite_a, ALUSrcA_a, IllegalOp_a;
  logic [1:0]  ALUSrcB_a, ALUOp_a, PCSource_a;
  logic [3:0]  State_a;
  logic [15:0] Retired_a;

  logic        PCWrite_b, IorD_b, MemRead_b, MemWrite_b, IRWrite_b, RegDst_b;
  logic        MemtoReg_b, RegWrite_b, ALUSrcA_b, IllegalOp_b;
  logic [1:0]  ALUSrcB_b, ALUOp_b, PCSource_b;
  logic [3:0]  State_b;
  logic [3:0]  Retired_b;

  always #5 CLK = ~CLK;

  multicycle_control dut16 (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite_a), .IorD(IorD_a), .MemRead(MemRead_a), .MemWrite(MemWrite_a),
    .IRWrite(IRWrite_a), .RegDst(RegDst_a), .MemtoReg(MemtoReg_a),
    .RegWrite(RegWrite_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
    .ALUOp(ALUOp_a), .PCSource(PCSource_a), .State(State_a),
    .IllegalOp(IllegalOp_a), .Retired(Retired_a)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite_b), .IorD(IorD_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b),
    .IRWrite(IRWrite_b), .RegDst(RegDst_b), .MemtoReg(MemtoReg_b),
    .RegWrite(RegWrite_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
    .ALUOp(ALUOp_b), .PCSource(PCSource_b), .State(State_b),
    .IllegalOp(IllegalOp_b), .Retired(Retired_b)
  );

  logic [14:0] outs_a, outs_b;
  assign outs_a = {PCWrite_a, IorD_a, MemRead_a, MemWrite_a, IRWrite_a, RegDst_a,
                   MemtoReg_a, RegWrite_a, ALUSrcA_a, ALUSrcB_a, ALUOp_a, PCSource_a};
  assign outs_b = {PCWrite_b, IorD_b, MemRead_b, MemWrite_b, IRWrite_b, RegDst_b,
                   MemtoReg_b, RegWrite_b, ALUSrcA_b, ALUSrcB_b, ALUOp_b, PCSource_b};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining steps of the current instruction.
  int   q[$];
  int   mret = 0;
  logic mill = 1'b0;
  bit   m_new = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Output table, one row per step.
  function automatic logic [14:0] exp_out(input int st, input logic mr,
                                          input logic z, input logic rst);
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca} = '0;
    srcb = 2'd0; aluop = 2'd0; pcsrc = 2'd0;
    case (st)
      0:  begin mrd = 1; srcb = 2'd1; irw = mr & ~rst; pcw = mr & ~rst; end
      1:  srcb = 2'd3;
      2:  begin srca = 1; srcb = 2'd2; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'd1; pcw = z; end
      9:  begin pcsrc = 2'd2; pcw = 1; end
      10: begin srca = 1; srcb = 2'd2; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aluop, pcsrc};
  endfunction

  task automatic model_update(input logic rst, input logic mr, input logic [5:0] op);
    int cur;
    m_new = 1'b0;
    if (rst) begin
      q = '{0, 1}; mret = 0; mill = 1'b0; m_new = 1'b1;
    end else begin
      cur = q[0];
      if (!((cur == 0 || cur == 3 || cur == 5) && !mr)) begin
        void'(q.pop_front());
        if (cur == 1) begin
          case (op)
            6'd0:    q = '{6, 7};
            6'd35:   q = '{2, 3, 4};
            6'd43:   q = '{2, 5};
            6'd4:    q = '{8};
            6'd2:    q = '{9};
            6'd8:    q = '{10, 11};
            default: mill = 1'b1;
          endcase
        end else if (q.size() == 0) begin
          mret++;
        end
        if (q.size() == 0) begin
          q = '{0, 1};
          m_new = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic mr, input logic z,
                      input logic [5:0] op, input bit do_chk);
    logic [14:0] e;
    RESET = rst; MemReady = mr; Zero = z; opcode = op;
    @(negedge CLK);
    if (do_chk) begin
      e = exp_out(q[0], mr, z, rst);
      chk("outs16", 32'(outs_a), 32'(e));
      chk("outs4", 32'(outs_b), 32'(e));
      chk("State16", 32'(State_a), 32'(q[0]));
      chk("State4", 32'(State_b), 32'(q[0]));
      chk("Retired16", 32'(Retired_a), 32'(mret & 32'hFFFF));
      chk("Retired4", 32'(Retired_b), 32'(mret & 32'hF));
      chk("IllegalOp16", 32'(IllegalOp_a), 32'(mill));
      chk("IllegalOp4", 32'(IllegalOp_b), 32'(mill));
    end
    @(posedge CLK);
    model_update(rst, mr, op);
    #1;
  endtask

  // Runs one instruction; MemReady drops for fst cycles in FETCH and for
  // mst cycles in the first MEMREAD/MEMWRITE step.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fst,
                           input int mst, output int cycles);
    int f, m, cur;
    logic mr;
    f = fst; m = mst; cycles = 0;
    do begin
      cur = q[0];
      mr = 1'b1;
      if (cur == 0 && f > 0) begin mr = 1'b0; f--; end
      if ((cur == 3 || cur == 5) && m > 0) begin mr = 1'b0; m--; end
      step(1'b0, mr, z, op, 1'b1);
      cycles++;
    end while (!m_new && cycles < 60);
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fst;
    int         mst;
    int         cyc;
    int         dret;
    logic       ill;
  } vec_t;

  vec_t vt[10];

  initial begin
    int cyc;
    logic [15:0] r0;
    vt[0] = '{6'd0,  1'b0, 0, 0, 4, 1, 1'b0};  // R-type
    vt[1] = '{6'd35, 1'b0, 0, 2, 7, 1, 1'b0};  // lw, 2-cycle MEMREAD stall
    vt[2] = '{6'd4,  1'b1, 0, 0, 3, 1, 1'b0};  // beq taken
    vt[3] = '{6'd4,  1'b0, 0, 0, 3, 1, 1'b0};  // beq not taken
    vt[4] = '{6'd8,  1'b0, 0, 0, 4, 1, 1'b0};  // addi
    vt[5] = '{6'd2,  1'b0, 0, 0, 3, 1, 1'b0};  // j
    vt[6] = '{6'h3F, 1'b0, 0, 0, 2, 0, 1'b1};  // illegal
    vt[7] = '{6'd43, 1'b0, 0, 0, 4, 1, 1'b1};  // sw after illegal, flag sticky
    vt[8] = '{6'd0,  1'b0, 2, 0, 6, 1, 1'b1};  // R-type, FETCH stall
    vt[9] = '{6'd43, 1'b1, 1, 3, 8, 1, 1'b1};  // sw, both stalls

    // Reset, then one more reset-held cycle with MemReady high.
    step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    chk("rst_State", 32'(State_a), 32'd0);
    chk("rst_Retired", 32'(Retired_a), 32'd0);
    chk("rst_IllegalOp", 32'(IllegalOp_a), 32'd0);
    step(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      r0 = Retired_a;
      run_instr(vt[i].op, vt[i].z, vt[i].fst, vt[i].mst, cyc);
      chk($sformatf("cycles[%0d]", i), 32'(cyc), 32'(vt[i].cyc));
      chk($sformatf("ret_delta[%0d]", i), 32'(16'(Retired_a - r0)), 32'(vt[i].dret));
      chk($sformatf("ill[%0d]", i), 32'(IllegalOp_a), 32'(vt[i].ill));
    end

    // Reset while stalled in MEMWRITE aborts the store.
    step(1'b0, 1'b1, 1'b0, 6'd43, 1'b1);
    step(1'b0, 1'b1, 1'b0, 6'd43, 1'b1);
    step(1'b0, 1'b1, 1'b0, 6'd43, 1'b1);
    chk("pre_abort_State", 32'(State_a), 32'd5);
    step(1'b1, 1'b0, 1'b0, 6'd43, 1'b1);
    chk("abort_State", 32'(State_a), 32'd0);
    chk("abort_MemWrite", 32'(MemWrite_a), 32'd0);
    chk("abort_Retired", 32'(Retired_a), 32'd0);
    chk("abort_IllegalOp", 32'(IllegalOp_a), 32'd0);

    // Counter wrap: 17 jumps on the 4-bit instance.
    step(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < 17; i++) run_instr(6'd2, 1'b0, 0, 0, cyc);
    chk("wrap_Retired4", 32'(Retired_b), 32'd1);
    chk("wrap_Retired16", 32'(Retired_a), 32'd17);

    // Random traffic; opcode is garbage outside DECODE.
    for (int i = 0; i < 3000; i++) begin
      logic rst, mr, z;
      logic [5:0] op;
      int sel;
      rst = ($urandom_range(0, 299) == 0);
      mr  = ($urandom_range(0, 3) != 0);
      z   = 1'($urandom);
      op  = 6'($urandom);
      if (q[0] == 1) begin
        sel = $urandom_range(0, 7);
        case (sel)
          0: op = 6'd0;
          1: op = 6'd35;
          2: op = 6'd43;
          3: op = 6'd4;
          4: op = 6'd2;
          5: op = 6'd8;
          default: ;
        endcase
      end
      step(rst, mr, z, op, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
